a429_rx_filter_mc: RTL and testbench

Multi-channel, dual-rail deglitch filter for the ARINC429 receive path. It sits between the line-receiver comparator outputs (HI and LO rail per channel) and the bit decoder. Each rail of each channel is filtered independently using a per-channel speed-selected persistence window. Each channel also provides a saturating glitch counter and a sticky illegal-state (HI and LO both high) flag for line-health monitoring.

---
 rtl/a429_rx_filter_mc.sv | 156 +++++++++++++++
 tb/tb_a429_rx_filter_mc.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a429_rx_filter_mc.sv
// a429_rx_filter_mc: multi-channel, dual-rail ARINC429 receive deglitch filter.
// Each HI/LO rail has a persistence-window FSM. Each channel has a saturating
// glitch counter and a sticky illegal-state (HI and LO both high) flag.
// Optional build macro: A429_RX_FILTER_SYNC_EN puts a 2-flop synchroniser on
// every raw rail input. This adds 2 cycles to every latency.
//
// state | meaning
// IDLE  | output stable; window counter preloaded with T-2 for the current speed
// CHECK | input differs from output; counting down the persistence window
module a429_rx_filter_mc #(
    parameter int CHANNELS   = 4,
    parameter int CLOCK_KHZ  = 100000,
    parameter int FILT_NS_HS = 3000,
    parameter int FILT_NS_LS = 24000,
    parameter int GCW        = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CHANNELS-1:0]     spd_i,
    input  logic [CHANNELS-1:0]     hi_i,
    input  logic [CHANNELS-1:0]     lo_i,
    input  logic [CHANNELS-1:0]     clr_i,
    output logic [CHANNELS-1:0]     hi_o,
    output logic [CHANNELS-1:0]     lo_o,
    output logic [CHANNELS-1:0]     err_o,
    output logic [CHANNELS*GCW-1:0] glitch_cnt_o
);

    // The product is computed in 64 bits because it overflows 32-bit int for slow windows.
    localparam int T_HS  = int'(longint'(CLOCK_KHZ) * longint'(FILT_NS_HS) / 64'd1000000);
    localparam int T_LS  = int'(longint'(CLOCK_KHZ) * longint'(FILT_NS_LS) / 64'd1000000);
    localparam int T_MAX = (T_HS > T_LS) ? T_HS : T_LS;
    // One extra bit so that the counter MSB marks the underflow.
    localparam int CW    = $clog2(T_MAX) + 1;
    localparam int R     = 2 * CHANNELS;

    localparam logic [CW-1:0] LOAD_HS = CW'(T_HS - 2);
    localparam logic [CW-1:0] LOAD_LS = CW'(T_LS - 2);

    if (T_HS < 2 || T_LS < 2) begin : g_bad_window
        $error("a429_rx_filter_mc: persistence window must be at least 2 cycles");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("a429_rx_filter_mc: CHANNELS must be 1..16");
    end

    typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} rail_state_t;

    // Rails 0..CHANNELS-1 are HI, rails CHANNELS..2*CHANNELS-1 are LO.
    logic [R-1:0] rail_raw;
    logic [R-1:0] rail_in;
    logic [R-1:0] rail_out;
    logic [R-1:0] abort;

    assign rail_raw = {lo_i, hi_i};

`ifdef A429_RX_FILTER_SYNC_EN
    logic [R-1:0] sync1;
    logic [R-1:0] sync2;

    // Two-flop synchroniser on every raw rail.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= rail_raw;
            sync2 <= sync1;
        end
    end
    assign rail_in = sync2;
`else
    assign rail_in = rail_raw;
`endif

    for (genvar r = 0; r < R; r++) begin : g_rail
        localparam int CH = r % CHANNELS;
        rail_state_t   state;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_dec;
        logic          out_q;

        assign cnt_dec     = cnt - CW'(1);
        assign abort[r]    = (state == CHECK) && (rail_in[r] == out_q);
        assign rail_out[r] = out_q;

        // Persistence window: the output toggles on the T-th consecutive differing sample.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                state <= IDLE;
                cnt   <= '0;
                out_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= spd_i[CH] ? LOAD_HS : LOAD_LS;
                        if (rail_in[r] != out_q) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (rail_in[r] == out_q) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt_dec;
                            if (cnt_dec[CW-1]) begin
                                out_q <= ~out_q;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign hi_o = rail_out[CHANNELS-1:0];
    assign lo_o = rail_out[R-1:CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [GCW-1:0] gcnt;
        logic [GCW:0]   gsum;
        logic           err_q;

        assign gsum = {1'b0, gcnt} + (GCW+1)'(abort[c]) + (GCW+1)'(abort[c+CHANNELS]);

        // Saturating glitch counter; a clear wins over a same-cycle increment.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                gcnt <= '0;
            end else if (clr_i[c]) begin
                gcnt <= '0;
            end else if (gsum[GCW]) begin
                gcnt <= '1;
            end else begin
                gcnt <= gsum[GCW-1:0];
            end
        end

        // Sticky illegal-state flag; it is set again after a clear if the condition persists.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                err_q <= 1'b0;
            end else if (clr_i[c]) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_q | (rail_out[c] & rail_out[c+CHANNELS]);
            end
        end

        assign err_o[c]                  = err_q;
        assign glitch_cnt_o[c*GCW +: GCW] = gcnt;
    end

endmodule

// File: tb/tb_a429_rx_filter_mc.sv
// Testbench for a429_rx_filter_mc: directed scenarios plus randomized rail
// activity, checked every cycle against a consecutive-sample reference model.
module tb_a429_rx_filter_mc;

    localparam int C          = 4;
    localparam int CLOCK_KHZ  = 100000;
    localparam int FILT_NS_HS = 3000;
    localparam int FILT_NS_LS = 24000;
    localparam int GCW        = 8;
    localparam int T_HS = int'(longint'(CLOCK_KHZ) * longint'(FILT_NS_HS) / 64'd1000000);
    localparam int T_LS = int'(longint'(CLOCK_KHZ) * longint'(FILT_NS_LS) / 64'd1000000);
    localparam int GMAX = (1 << GCW) - 1;
`ifdef A429_RX_FILTER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [C-1:0]     spd_i, hi_i, lo_i, clr_i;
    logic [C-1:0]     hi_o, lo_o, err_o;
    logic [C*GCW-1:0] glitch_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: a rail output flips once the sampled input has differed
    // from it for T consecutive samples (T fixed by the speed at the first sample).
    bit           m_out [2*C];
    int           m_n   [2*C];
    int           m_t   [2*C];
    int           m_g   [C];
    bit           m_err [C];
    logic [2*C-1:0] m_s1, m_s2;

    a429_rx_filter_mc #(
        .CHANNELS(C), .CLOCK_KHZ(CLOCK_KHZ), .FILT_NS_HS(FILT_NS_HS),
        .FILT_NS_LS(FILT_NS_LS), .GCW(GCW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .spd_i(spd_i), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o), .clr_i(clr_i),
        .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2*C; r++) begin
            m_out[r] = 1'b0; m_n[r] = 0; m_t[r] = 0;
        end
        for (int c = 0; c < C; c++) begin
            m_g[c] = 0; m_err[c] = 1'b0;
        end
        m_s1 = '0; m_s2 = '0;
    endtask

    task automatic model_edge();
        logic [2*C-1:0] raw, smp;
        bit old_both [C];
        int ab [C];
        raw = {lo_i, hi_i};
        if (!rst_i) begin
            model_reset();
            return;
        end
`ifdef A429_RX_FILTER_SYNC_EN
        smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
`else
        smp = raw;
`endif
        for (int c = 0; c < C; c++) begin
            old_both[c] = m_out[c] && m_out[c+C];
            ab[c] = 0;
        end
        for (int r = 0; r < 2*C; r++) begin
            if (m_n[r] == 0) begin
                if (smp[r] != m_out[r]) begin
                    m_t[r] = spd_i[r % C] ? T_HS : T_LS;
                    m_n[r] = 1;
                end
            end else if (smp[r] == m_out[r]) begin
                m_n[r] = 0;
                ab[r % C]++;
            end else begin
                m_n[r]++;
                if (m_n[r] == m_t[r]) begin
                    m_out[r] = ~m_out[r];
                    m_n[r] = 0;
                end
            end
        end
        for (int c = 0; c < C; c++) begin
            if (clr_i[c]) begin
                m_g[c] = 0; m_err[c] = 1'b0;
            end else begin
                m_g[c] = (m_g[c] + ab[c] > GMAX) ? GMAX : m_g[c] + ab[c];
                m_err[c] = m_err[c] | old_both[c];
            end
        end
    endtask

    task automatic compare_all();
        logic [C-1:0] eh, el, ee;
        logic [C*GCW-1:0] eg;
        for (int c = 0; c < C; c++) begin
            eh[c] = m_out[c];
            el[c] = m_out[c+C];
            ee[c] = m_err[c];
            eg[c*GCW +: GCW] = GCW'(m_g[c]);
        end
        chk("hi_o", 64'(hi_o), 64'(eh));
        chk("lo_o", 64'(lo_o), 64'(el));
        chk("err_o", 64'(err_o), 64'(ee));
        chk("glitch_cnt", 64'(glitch_cnt_o), 64'(eg));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic int pick_hold();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(1, 20);
            1:       return $urandom_range(280, 320);
            2:       return $urandom_range(2380, 2420);
            default: return $urandom_range(30, 600);
        endcase
    endfunction

    initial begin
        int lat;
        int hold [2*C];
        rst_i = 1'b0;
        spd_i = '1;
        hi_i  = '0;
        lo_i  = '0;
        clr_i = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_glitch", 64'(glitch_cnt_o), 64'd0);
        rst_i = 1'b1;
        spd_i[1] = 1'b0;
        tick();

        // High-speed rise latency on hi rail 0.
        hi_i[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (hi_o[0]) begin lat = i; break; end
        end
        chk("s1_latency", 64'(lat), 64'(T_HS + LAT));
        chk("s1_glitch0", 64'(glitch_cnt_o[0 +: GCW]), 64'd0);

        // Low-speed pulse one cycle short of the window, then one exactly the window.
        lo_i[1] = 1'b1;
        repeat (T_LS - 1) tick();
        lo_i[1] = 1'b0;
        repeat (10) tick();
        chk("s2_short_lo", 64'(lo_o[1]), 64'd0);
        chk("s2_glitch1", 64'(glitch_cnt_o[GCW +: GCW]), 64'd1);
        lo_i[1] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (lo_o[1]) begin lat = i; break; end
        end
        chk("s2_latency", 64'(lat), 64'(T_LS + LAT));

        // Glitch counter saturation, then a clear that coincides with an abort.
        for (int p = 0; p < 260; p++) begin
            hi_i[2] = 1'b1;
            repeat (10) tick();
            hi_i[2] = 1'b0;
            repeat (10) tick();
        end
        chk("s3_saturate", 64'(glitch_cnt_o[2*GCW +: GCW]), 64'(GMAX));
        hi_i[2] = 1'b1;
        repeat (10) tick();
        hi_i[2] = 1'b0;
        repeat (LAT) tick();
        clr_i[2] = 1'b1;
        tick();
        clr_i[2] = 1'b0;
        chk("s3_clr_wins", 64'(glitch_cnt_o[2*GCW +: GCW]), 64'd0);

        // Illegal state on channel 3: sticky until cleared.
        hi_i[3] = 1'b1;
        lo_i[3] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (err_o[3] && lat < 0) lat = i;
        end
        chk("s4_err_set", 64'(lat), 64'(T_HS + 1 + LAT));
        hi_i[3] = 1'b0;
        lo_i[3] = 1'b0;
        repeat (400) tick();
        chk("s4_err_sticky", 64'(err_o[3]), 64'd1);
        clr_i[3] = 1'b1;
        tick();
        clr_i[3] = 1'b0;
        chk("s4_err_clr", 64'(err_o[3]), 64'd0);

        // Speed change mid-window keeps the loaded count; next window is slow.
        hi_i[0] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 1000; i++) begin
            if (i == 101) spd_i[0] = 1'b0;
            tick();
            if (!hi_o[0]) begin lat = i; break; end
        end
        chk("s5_fall_latency", 64'(lat), 64'(T_HS + LAT));
        hi_i[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (hi_o[0]) begin lat = i; break; end
        end
        chk("s5_slow_latency", 64'(lat), 64'(T_LS + LAT));
        spd_i[0] = 1'b1;

        // Reset in the middle of a window.
        hi_i[0] = 1'b0;
        repeat (T_LS + LAT + 10) tick();
        hi_i[0] = 1'b1;
        repeat (150) tick();
        rst_i = 1'b0;
        #1;
        chk("s6_rst_hi", 64'(hi_o), 64'd0);
        chk("s6_rst_lo", 64'(lo_o), 64'd0);
        repeat (3) tick();
        rst_i = 1'b1;
        lat = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (hi_o[0]) begin lat = i; break; end
        end
        chk("s6_post_rst_latency", 64'(lat), 64'(T_HS + LAT));

        // Randomized rail activity, speed changes and clears.
        for (int r = 0; r < 2*C; r++) hold[r] = pick_hold();
        repeat (20000) begin
            for (int r = 0; r < 2*C; r++) begin
                hold[r]--;
                if (hold[r] <= 0) begin
                    if (r < C) hi_i[r] = ~hi_i[r];
                    else       lo_i[r-C] = ~lo_i[r-C];
                    hold[r] = pick_hold();
                end
            end
            clr_i = '0;
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(0, 499) == 0) spd_i[c] = ~spd_i[c];
                if ($urandom_range(0, 299) == 0) clr_i[c] = 1'b1;
            end
            tick();
        end
        clr_i = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
